// File: rtl/seven_seg_scan_scheduler.sv
// Four-digit multiplexed seven-segment scan sequencer with dead-time blanking,
// message/primary arbitration, leading-zero blanking and per-digit blink.
module seven_seg_scan_scheduler #(
  parameter int ON_CYCLES    = 3,
  parameter int DEAD_CYCLES  = 1,
  parameter int MSG_FRAMES   = 250,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        kHzclk,
  input  logic        reset,
  input  logic [15:0] pri_value,
  input  logic        msg_req,
  input  logic [15:0] msg_value,
  input  logic        lz_blank_en,
  input  logic [3:0]  blink_mask,
  output logic [3:0]  AN,
  output logic [3:0]  small_bin,
  output logic        msg_grant,
  output logic        msg_done,
  output logic        frame_tick
);

  localparam int SW = $clog2(ON_CYCLES + DEAD_CYCLES + 1);
  localparam int FW = $clog2(MSG_FRAMES + 1);
  localparam int BW = $clog2(BLINK_FRAMES + 1);

  localparam logic [0:0] PH_ON   = 1'b0;
  localparam logic [0:0] PH_DEAD = 1'b1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT   = 2'd1;
  localparam logic [1:0] ST_HOLDOFF = 2'd2;

  // Scan position: the digit/slot/phase the next clock edge will display.
  logic [1:0]    digit, digit_nx;
  logic [SW-1:0] slot, slot_nx;
  logic [0:0]    phase, phase_nx;

  logic [1:0]    state, state_nx;
  logic [FW-1:0] frame_cnt, frame_cnt_nx;
  logic          grant_nx, done_nx;

  logic [BW-1:0] blink_cnt, blink_cnt_nx;
  logic          blink_phase, blink_phase_nx;

  logic [15:0]   snap, eff_snap;
  logic [3:0]    mask, eff_mask;
  logic          frame_start, lz_hit, blanked;
  logic [3:0]    nibble;

  // NOTE: every variable assigned in this block gets a default first, so no latch is inferred.
  always_comb begin
    frame_start  = (digit == 2'd0) && (slot == '0) && (phase == PH_ON);

    state_nx     = state;
    frame_cnt_nx = frame_cnt;
    grant_nx     = msg_grant;
    done_nx      = 1'b0;
    if (frame_start) begin
      case (state)
        ST_IDLE: if (msg_req) begin
          state_nx     = ST_GRANT;
          frame_cnt_nx = '0;
          grant_nx     = 1'b1;
        end
        ST_GRANT: begin
          frame_cnt_nx = frame_cnt + FW'(1);
          // Expiry and req drop at the same boundary collapse into one ending.
          if (frame_cnt_nx == FW'(MSG_FRAMES) || !msg_req) begin
            state_nx = ST_HOLDOFF;
            grant_nx = 1'b0;
            done_nx  = 1'b1;
          end
        end
        ST_HOLDOFF: if (!msg_req) state_nx = ST_IDLE;
        default:    state_nx = ST_IDLE;
      endcase
    end

    blink_cnt_nx   = blink_cnt;
    blink_phase_nx = blink_phase;
    if (frame_start) begin
      if (blink_cnt == BW'(BLINK_FRAMES)) begin
        blink_phase_nx = ~blink_phase;
        blink_cnt_nx   = BW'(1);
      end else begin
        blink_cnt_nx = blink_cnt + BW'(1);
      end
    end

    // The frame's first cycle displays the freshly latched snapshot.
    eff_snap = frame_start ? (grant_nx ? msg_value : pri_value) : snap;
    eff_mask = frame_start ? blink_mask : mask;

    case (digit)
      2'd1:    lz_hit = (eff_snap[15:4] == '0);
      2'd2:    lz_hit = (eff_snap[15:8] == '0);
      2'd3:    lz_hit = (eff_snap[15:12] == '0);
      default: lz_hit = 1'b0;
    endcase
    blanked = (lz_blank_en && lz_hit) || (blink_phase_nx && eff_mask[digit]);
    nibble  = 4'(eff_snap >> {digit, 2'b00});

    digit_nx = digit;
    slot_nx  = slot + SW'(1);
    phase_nx = phase;
    if (phase == PH_ON && slot == SW'(ON_CYCLES - 1)) begin
      slot_nx = '0;
      if (DEAD_CYCLES > 0) phase_nx = PH_DEAD;
      else                 digit_nx = digit + 2'd1;
    end else if (phase == PH_DEAD && slot == SW'(DEAD_CYCLES - 1)) begin
      slot_nx  = '0;
      phase_nx = PH_ON;
      digit_nx = digit + 2'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge kHzclk or posedge reset) begin
    if (reset) begin
      digit       <= 2'd0;
      slot        <= '0;
      phase       <= PH_ON;
      state       <= ST_IDLE;
      frame_cnt   <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      snap        <= '0;
      mask        <= '0;
      AN          <= 4'hF;
      small_bin   <= 4'h0;
      msg_grant   <= 1'b0;
      msg_done    <= 1'b0;
      frame_tick  <= 1'b0;
    end else begin
      digit       <= digit_nx;
      slot        <= slot_nx;
      phase       <= phase_nx;
      state       <= state_nx;
      frame_cnt   <= frame_cnt_nx;
      blink_cnt   <= blink_cnt_nx;
      blink_phase <= blink_phase_nx;
      snap        <= eff_snap;
      mask        <= eff_mask;
      msg_grant   <= grant_nx;
      msg_done    <= done_nx;
      frame_tick  <= frame_start;
      if (phase == PH_ON) begin
        AN        <= blanked ? 4'hF : ~(4'b0001 << digit);
        small_bin <= nibble;
      end else begin
        AN        <= 4'hF;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_scheduler.sv
// Randomized bench for seven_seg_scan_scheduler: a frame/position model derived
// from cycle count since reset predicts every output on every cycle.
module tb_seven_seg_scan_scheduler;

  localparam int ON  = 3;
  localparam int DC  = 1;
  localparam int MF  = 3;
  localparam int BF  = 2;
  localparam int SL  = ON + DC;
  localparam int FL  = 4 * SL;

  logic        kHzclk = 1'b0;
  logic        reset  = 1'b1;
  logic [15:0] pri_value = 16'h1234;
  logic        msg_req = 1'b0;
  logic [15:0] msg_value = 16'hBEEF;
  logic        lz_blank_en = 1'b0;
  logic [3:0]  blink_mask = 4'b0000;
  logic [3:0]  AN, small_bin;
  logic        msg_grant, msg_done, frame_tick;

  seven_seg_scan_scheduler #(
    .ON_CYCLES(ON), .DEAD_CYCLES(DC), .MSG_FRAMES(MF), .BLINK_FRAMES(BF)
  ) dut (
    .kHzclk(kHzclk), .reset(reset), .pri_value(pri_value), .msg_req(msg_req),
    .msg_value(msg_value), .lz_blank_en(lz_blank_en), .blink_mask(blink_mask),
    .AN(AN), .small_bin(small_bin), .msg_grant(msg_grant), .msg_done(msg_done),
    .frame_tick(frame_tick)
  );

  always #5 kHzclk = ~kHzclk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Reference model state
  typedef enum {M_IDLE, M_GRANT, M_HOLD} arb_e;
  arb_e        m_st;
  int          m_fc;
  int          t;
  logic        m_grant, m_done, m_tick;
  logic [15:0] m_snap;
  logic [3:0]  m_mask, m_an, m_sb;
  int          req_hold;

  task automatic model_reset();
    t = 0; m_st = M_IDLE; m_fc = 0; m_grant = 0; m_done = 0; m_tick = 0;
    m_snap = '0; m_mask = '0; m_an = 4'hF; m_sb = 4'h0;
  endtask

  // Predict outputs after edge number t using the inputs present at that edge.
  task automatic model_step();
    int pos, f, sl, w;
    logic blank;
    pos = t % FL; f = t / FL; sl = pos / SL; w = pos % SL;
    m_done = 1'b0;
    m_tick = (pos == 0);
    if (pos == 0) begin
      case (m_st)
        M_IDLE: if (msg_req) begin m_st = M_GRANT; m_fc = 0; m_grant = 1'b1; end
        M_GRANT: begin
          m_fc++;
          if (m_fc == MF || !msg_req) begin m_st = M_HOLD; m_grant = 1'b0; m_done = 1'b1; end
        end
        M_HOLD: if (!msg_req) m_st = M_IDLE;
        default: m_st = M_IDLE;
      endcase
      m_snap = m_grant ? msg_value : pri_value;
      m_mask = blink_mask;
    end
    if (w < ON) begin
      blank = (lz_blank_en && sl > 0 && (m_snap >> (4 * sl)) == 16'h0) ||
              (((f / BF) % 2) == 1 && m_mask[sl]);
      m_an = blank ? 4'hF : ~(4'b0001 << sl);
      m_sb = m_snap[4 * sl +: 4];
    end else begin
      m_an = 4'hF;
    end
    t++;
  endtask

  function automatic logic [15:0] rand_val();
    logic [15:0] v;
    for (int i = 0; i < 4; i++)
      v[4 * i +: 4] = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
    return v;
  endfunction

  task automatic drive_inputs(input bit rand_req);
    if ($urandom_range(0, 7) == 0) pri_value = rand_val();
    if ($urandom_range(0, 15) == 0) msg_value = rand_val();
    if ($urandom_range(0, 7) == 0) blink_mask = 4'($urandom);
    if ((t % FL) == 0 && $urandom_range(0, 3) == 0) lz_blank_en = ~lz_blank_en;
    if (rand_req) begin
      if (req_hold == 0) begin
        msg_req  = ~msg_req;
        req_hold = $urandom_range(3, 120);
      end else begin
        req_hold--;
      end
    end
  endtask

  task automatic run_cycles(input int n, input bit rand_req);
    for (int i = 0; i < n; i++) begin
      @(negedge kHzclk);
      model_step();
      check("AN", AN, m_an);
      check("small_bin", small_bin, m_sb);
      check("msg_grant", msg_grant, m_grant);
      check("msg_done", msg_done, m_done);
      check("frame_tick", frame_tick, m_tick);
      drive_inputs(rand_req);
    end
  endtask

  task automatic check_in_reset(input string tag);
    check({tag, "_AN"}, AN, 4'hF);
    check({tag, "_grant"}, msg_grant, 1'b0);
    check({tag, "_done"}, msg_done, 1'b0);
    check({tag, "_tick"}, frame_tick, 1'b0);
  endtask

  initial begin
    req_hold = 40;
    model_reset();
    repeat (3) @(negedge kHzclk);
    check_in_reset("rst");
    check("rst_small_bin", small_bin, 4'h0);
    @(negedge kHzclk);
    reset = 1'b0;

    // First two frames with fixed inputs: 1234 shown as 4,3,2,1.
    run_cycles(2 * FL, 1'b0);

    for (int seg = 0; seg < 5; seg++) begin
      run_cycles(600, 1'b1);
      // Force a grant, drop the request mid-frame, then reset 5 cycles later.
      msg_req = 1'b0;
      run_cycles(2 * FL + 3, 1'b0);
      msg_req = 1'b1;
      for (int k = 0; k < 3 * FL && !m_grant; k++) run_cycles(1, 1'b0);
      check("grant_reached", m_grant, 1'b1);
      run_cycles($urandom_range(2, 2 * FL), 1'b0);
      msg_req = 1'b0;
      run_cycles(5, 1'b0);
      @(posedge kHzclk);
      #2 reset = 1'b1;
      #1 check_in_reset("midrst");
      repeat (2) @(negedge kHzclk);
      check_in_reset("midrst_hold");
      reset = 1'b0;
      model_reset();
      req_hold = $urandom_range(3, 60);
    end

    run_cycles(200, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
